// File: rtl/nested_loop_counter.sv
// nested_loop_counter: two-level loop index generator with start/busy/done handshake; optional abort input via NESTED_LOOP_ABORT_EN
module nested_loop_counter #(
  parameter int IW = 8,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] inner_lim,
  input  logic [OW-1:0] outer_lim,
  input  logic          advance,
`ifdef NESTED_LOOP_ABORT_EN
  input  logic          abort,
`endif
  output logic [IW-1:0] inner_idx,
  output logic [OW-1:0] outer_idx,
  output logic          valid,
  output logic          inner_last,
  output logic          outer_last,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] inner_lim_q;
  logic [OW-1:0] outer_lim_q;
  logic abort_i, in_end, out_end, kill;
`ifdef NESTED_LOOP_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif
  assign in_end  = inner_idx == inner_lim_q;
  assign out_end = outer_idx == outer_lim_q;
  assign kill    = abort_i && state != IDLE;
  // state register; reset discards any nest in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  // next state: abort wins, final advance goes through DONE for the completion pulse
  always_comb begin
    state_nx = kill ? IDLE :
               state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (advance && in_end && out_end ? DONE : RUN) : IDLE;
  end
  // limits latch on accepted start; indices step inner-first and return to 0 on completion
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      inner_idx   <= '0;
      outer_idx   <= '0;
      inner_lim_q <= '0;
      outer_lim_q <= '0;
    end else if (state == IDLE && start) begin
      inner_idx   <= '0;
      outer_idx   <= '0;
      inner_lim_q <= inner_lim;
      outer_lim_q <= outer_lim;
    end else if (kill) begin
      inner_idx <= '0;
      outer_idx <= '0;
    end else if (state == RUN && advance) begin
      inner_idx <= in_end ? '0 : inner_idx + IW'(1);
      outer_idx <= !in_end ? outer_idx : out_end ? '0 : outer_idx + OW'(1);
    end
  // status decoded from the registered state
  always_comb begin
    valid      = state == RUN;
    busy       = state != IDLE;
    done       = state == DONE;
    inner_last = valid && in_end;
    outer_last = valid && out_end;
  end
endmodule

// File: tb/tb_nested_loop_counter.sv
// tb_nested_loop_counter: table, hand-written and random checks against an arithmetic pair-count model
module tb_nested_loop_counter;
`ifdef NESTED_LOOP_ABORT_EN
  localparam bit AB = 1'b1;
`else
  localparam bit AB = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, advance, abort;
  logic [7:0] il, ol;
  logic [7:0] ii, oi;
  logic v, inl, onl, b, d;
  logic [1:0] ii2, oi2;
  logic v2, inl2, onl2, b2, d2;
  int n_chk = 0, n_fail = 0;
  int ph, k, li, lo;
  bit chk2 = 1'b0;

  nested_loop_counter dut (
    .clk(clk), .rst(rst), .start(start), .inner_lim(il), .outer_lim(ol), .advance(advance),
`ifdef NESTED_LOOP_ABORT_EN
    .abort(abort),
`endif
    .inner_idx(ii), .outer_idx(oi), .valid(v), .inner_last(inl), .outer_last(onl), .busy(b), .done(d)
  );

  nested_loop_counter #(.IW(2), .OW(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .inner_lim(il[1:0]), .outer_lim(ol[1:0]), .advance(advance),
`ifdef NESTED_LOOP_ABORT_EN
    .abort(abort),
`endif
    .inner_idx(ii2), .outer_idx(oi2), .valid(v2), .inner_last(inl2), .outer_last(onl2), .busy(b2), .done(d2)
  );

  typedef struct { int il; int ol; int pairs; int cycles; } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int ein, eout;
    bit ev;
    ev   = ph == 1;
    ein  = ev ? k % (li + 1) : 0;
    eout = ev ? k / (li + 1) : 0;
    chk("inner_idx", ii, ein);
    chk("outer_idx", oi, eout);
    chk("valid", v, ev);
    chk("inner_last", inl, ev && ein == li);
    chk("outer_last", onl, ev && eout == lo);
    chk("busy", b, ph != 0);
    chk("done", d, ph == 2);
    if (chk2) begin
      chk("w2_inner_idx", ii2, ein);
      chk("w2_outer_idx", oi2, eout);
      chk("w2_valid", v2, ev);
      chk("w2_last", {inl2, onl2}, {ev && ein == li, ev && eout == lo});
      chk("w2_busy_done", {b2, d2}, {ph != 0, ph == 2});
    end
  endtask

  task automatic model_step();
    if (ph == 0) begin
      if (start) begin li = il; lo = ol; k = 0; ph = 1; end
    end else if (AB && abort) begin
      ph = 0; k = 0;
    end else if (ph == 1) begin
      if (advance) begin
        if (k == (li + 1) * (lo + 1) - 1) begin ph = 2; k = 0; end
        else k++;
      end
    end else ph = 0;
  endtask

  task automatic step(input bit s, input bit a, input bit ab);
    start = s; advance = a; abort = ab;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    ph = 0; k = 0; li = 0; lo = 0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic run_nest(input int nil, input int nol, input int ep, input int ec);
    int pairs, cyc, dn;
    il = 8'(nil); ol = 8'(nol);
    step(1, 1, 0);
    pairs = 0; cyc = 1; dn = 0;
    while (b && cyc < ec + 20) begin
      if (v) pairs++;
      step(0, 1, 0);
      cyc++;
      dn += int'(d);
    end
    chk("nest_no_timeout", int'(b), 0);
    chk("nest_pairs", pairs, ep);
    chk("nest_cycles", cyc, ec);
    chk("nest_done_pulses", dn, 1);
  endtask

  initial begin
    int pairs, dn;
    bit seen;
    tbl[0] = '{2, 1, 6, 8};
    tbl[1] = '{0, 0, 1, 3};
    tbl[2] = '{3, 0, 4, 6};
    tbl[3] = '{0, 2, 3, 5};
    tbl[4] = '{4, 3, 20, 22};
    tbl[5] = '{7, 7, 64, 66};
    start = 0; advance = 0; abort = 0; il = 0; ol = 0;
    rst = 1'b0;
    @(posedge clk);
    do_reset();

    for (int i = 0; i < 6; i++) run_nest(tbl[i].il, tbl[i].ol, tbl[i].pairs, tbl[i].cycles);

    il = 0; ol = 0;
    step(1, 0, 0);
    chk("degen_pair", {ii, oi}, 0);
    chk("degen_lasts", {inl, onl}, 2'b11);
    step(0, 1, 0);
    chk("degen_done", d, 1);
    step(0, 0, 0);
    chk("degen_idle", b, 0);

    il = 2; ol = 1;
    step(1, 1, 0);
    il = 7; ol = 7;
    step(1, 1, 0);
    step(1, 0, 0);
    chk("stall_hold", ii, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("stall_inner_lim_kept", {ii, 7'b0, inl}, {8'd2, 7'b0, 1'b1});
    step(1, 1, 0);
    chk("stall_outer_lim_kept", {oi, 7'b0, onl}, {8'd1, 7'b0, 1'b1});
    for (int i = 0; i < 3 && b; i++) step(0, 1, 0);
    step(0, 1, 0);
    chk("stall_end_idle", b, 0);

    il = 2; ol = 1;
    step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    chk("pre_reset_pos", {oi, ii}, {8'd1, 8'd2});
    #3;
    do_reset();
    chk("reset_mid_run", {ii, oi, 5'b0, v, b, d}, 0);
    dn = 0;
    for (int i = 0; i < 4; i++) begin step(0, 0, 0); dn += int'(d); end
    chk("reset_no_done", dn, 0);

    do_reset();
    chk2 = 1'b1;
    il = 3; ol = 3;
    step(1, 1, 0);
    pairs = 0; seen = 0;
    for (int i = 0; i < 40 && b2; i++) begin
      if (v2) pairs++;
      if (v2 && ii2 == 2'd3 && oi2 == 2'd3) seen = 1;
      step(0, 1, 0);
    end
    chk("w2_pairs", pairs, 16);
    chk("w2_last_pair_seen", seen, 1);
    chk2 = 1'b0;

    if (AB) begin
      il = 3; ol = 1;
      step(1, 1, 0);
      step(0, 1, 0);
      chk("abort_pos", {oi, ii}, {8'd0, 8'd1});
      step(1, 1, 1);
      chk("abort_idle", {5'b0, v, b, d}, 0);
      step(1, 1, 0);
      chk("abort_restart", {v, b}, 2'b11);
      for (int i = 0; i < 12 && b; i++) step(0, 1, 0);
    end

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      il = 8'($urandom_range(0, 5));
      ol = 8'($urandom_range(0, 4));
      step($urandom % 3 == 0, $urandom % 4 != 0, AB && ($urandom % 40 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
